// File: rtl/topk_drain.sv
// Top-K drain: captures one ascending-sorted N-lane vector with its sideband and
// streams the K largest lanes out serially, largest first, over valid/ready.
module topk_drain #(
    parameter int DATAWIDTH = 8,
    parameter int N         = 16,
    parameter int K         = 4,
    parameter int CTRLW     = 4,
    localparam int RW       = (K > 1) ? $clog2(K) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   vec_valid_i,
    output logic                   vec_ready_o,
    input  logic [N*DATAWIDTH-1:0] vec_i,
    input  logic [CTRLW-1:0]       ctrl_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATAWIDTH-1:0]   out_data_o,
    output logic [RW-1:0]          out_rank_o,
    output logic                   out_last_o,
    output logic [CTRLW-1:0]       ctrl_o,
    output logic                   busy_o
);

    generate
        if (K < 1 || K > N || N < 2) begin : g_param_check
            $error("topk_drain: requires N >= 2 and 1 <= K <= N");
        end
    endgenerate

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [RW-1:0]          rank_q, rank_d;
    logic [K*DATAWIDTH-1:0] cap_q, cap_d;
    logic [CTRLW-1:0]       ctrl_q, ctrl_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATAWIDTH-1:0]   out_data_q, out_data_d;
    logic [RW-1:0]          out_rank_q, out_rank_d;
    logic                   out_last_q, out_last_d;
    logic                   out_fire;
    logic                   vec_ready;

    // Only the top K lanes are kept; the lower lanes are intentionally dropped.
    logic [N*DATAWIDTH-1:0] unused_vec;
    assign unused_vec = vec_i;

    // Rank r maps to captured lane K-1-r (captured lane K-1 is the input's max lane).
    function automatic logic [DATAWIDTH-1:0] lane_sel(input logic [K*DATAWIDTH-1:0] cap,
                                                      input logic [RW-1:0] r);
        lane_sel = '0;
        for (int i = 0; i < K; i++) begin
            if (r == RW'(i)) lane_sel = cap[(K-1-i)*DATAWIDTH +: DATAWIDTH];
        end
    endfunction

    assign out_fire  = out_valid_q && out_ready_i;
    assign vec_ready = (state_q == IDLE) || (out_fire && out_last_q);

    always_comb begin
        state_d = state_q;
        rank_d  = rank_q;
        cap_d   = cap_q;
        ctrl_d  = ctrl_q;
        if (vec_valid_i && vec_ready) begin
            cap_d   = vec_i[N*DATAWIDTH-1 -: K*DATAWIDTH];
            ctrl_d  = ctrl_i;
            rank_d  = '0;
            state_d = DRAIN;
        end else if (out_fire) begin
            if (out_last_q) state_d = IDLE;
            else            rank_d  = rank_q + RW'(1);
        end
        // Outputs are registered copies of the next state so nothing is combinational from vec_valid_i.
        out_valid_d = (state_d == DRAIN);
        out_data_d  = (state_d == DRAIN) ? lane_sel(cap_d, rank_d) : '0;
        out_rank_d  = (state_d == DRAIN) ? rank_d : '0;
        out_last_d  = (state_d == DRAIN) && (rank_d == RW'(K-1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rank_q      <= '0;
            cap_q       <= '0;
            ctrl_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rank_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rank_q      <= rank_d;
            cap_q       <= cap_d;
            ctrl_q      <= ctrl_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rank_q  <= out_rank_d;
            out_last_q  <= out_last_d;
        end
    end

    assign vec_ready_o = vec_ready;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_rank_o  = out_rank_q;
    assign out_last_o  = out_last_q;
    assign ctrl_o      = ctrl_q;
    assign busy_o      = (state_q == DRAIN);

endmodule

// File: tb/tb_topk_drain.sv
// Directed bench for topk_drain: K=4 main instance plus K=1 and K=16 builds.
module tb_topk_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         vv, vr, ov, ordy, olast, busy;
    logic [127:0] vec;
    logic [3:0]   ctrl, octrl;
    logic [7:0]   od;
    logic [1:0]   orank;

    // index 0: K=1 build, index 1: K=16 build
    logic         s_vv [2];
    logic         s_vr [2];
    logic [127:0] s_vec [2];
    logic [3:0]   s_ctrl [2];
    logic         s_ov [2];
    logic         s_or [2];
    logic [7:0]   s_od [2];
    logic         s_last [2];
    logic [3:0]   s_octrl [2];
    logic         s_busy [2];
    logic [0:0]   rank1;
    logic [3:0]   rankn;

    int nvec = 0;
    int nerr = 0;

    topk_drain #(.DATAWIDTH(8), .N(16), .K(4), .CTRLW(4)) dut (
        .clk_i(clk), .rst_i(rst), .vec_valid_i(vv), .vec_ready_o(vr), .vec_i(vec),
        .ctrl_i(ctrl), .out_valid_o(ov), .out_ready_i(ordy), .out_data_o(od),
        .out_rank_o(orank), .out_last_o(olast), .ctrl_o(octrl), .busy_o(busy));

    topk_drain #(.DATAWIDTH(8), .N(16), .K(1), .CTRLW(4)) dut_k1 (
        .clk_i(clk), .rst_i(rst), .vec_valid_i(s_vv[0]), .vec_ready_o(s_vr[0]), .vec_i(s_vec[0]),
        .ctrl_i(s_ctrl[0]), .out_valid_o(s_ov[0]), .out_ready_i(s_or[0]), .out_data_o(s_od[0]),
        .out_rank_o(rank1), .out_last_o(s_last[0]), .ctrl_o(s_octrl[0]), .busy_o(s_busy[0]));

    topk_drain #(.DATAWIDTH(8), .N(16), .K(16), .CTRLW(4)) dut_kn (
        .clk_i(clk), .rst_i(rst), .vec_valid_i(s_vv[1]), .vec_ready_o(s_vr[1]), .vec_i(s_vec[1]),
        .ctrl_i(s_ctrl[1]), .out_valid_o(s_ov[1]), .out_ready_i(s_or[1]), .out_data_o(s_od[1]),
        .out_rank_o(rankn), .out_last_o(s_last[1]), .ctrl_o(s_octrl[1]), .busy_o(s_busy[1]));

    typedef struct {
        logic [7:0] d;
        int         r;
        logic       l;
        logic [3:0] c;
    } beat_t;

    function automatic logic [127:0] mkvec(input logic [7:0] base);
        logic [127:0] v;
        for (int j = 0; j < 16; j++) v[j*8 +: 8] = base + 8'(j);
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; vv = 1'b0; ordy = 1'b0; vec = '0; ctrl = '0;
        repeat (2) @(negedge clk);
        nvec++;
        if ({ov, od, orank, olast, octrl, busy, vr} !== {1'b0, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1}) begin
            nerr++;
            $display("FAIL reset_state: got ov=%b od=%h rank=%0d last=%b ctrl=%h busy=%b vr=%b, want 0,00,0,0,0,0,1",
                     ov, od, orank, olast, octrl, busy, vr);
        end
        nvec++;
        if ({s_ov[0], s_ov[1], s_busy[0], s_busy[1], s_vr[0], s_vr[1]} !== 6'b000011) begin
            nerr++;
            $display("FAIL reset_state_k1_kn: got ov=%b%b busy=%b%b vr=%b%b, want 00 00 11",
                     s_ov[0], s_ov[1], s_busy[0], s_busy[1], s_vr[0], s_vr[1]);
        end
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if ({ov, busy, vr} !== 3'b001) begin
            nerr++;
            $display("FAIL post_reset_idle: got ov=%b busy=%b vr=%b, want 0 0 1", ov, busy, vr);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_d;
        vv = 1'b1; vec = mkvec(8'h00); ctrl = 4'h2; ordy = 1'b1;
        #1;
        nvec++;
        if (vr !== 1'b1) begin
            nerr++;
            $display("FAIL basic_idle_ready: got vr=%b, want 1", vr);
        end
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            vv = 1'b0;
            #1;
            exp_d = 8'h0F - 8'(r);
            nvec++;
            if ({ov, od, orank, olast, octrl, busy} !== {1'b1, exp_d, 2'(r), (r == 3), 4'h2, 1'b1}) begin
                nerr++;
                $display("FAIL basic_beat%0d: got ov=%b od=%h rank=%0d last=%b ctrl=%h busy=%b, want 1,%h,%0d,%b,2,1",
                         r, ov, od, orank, olast, octrl, busy, exp_d, r, (r == 3));
            end
            nvec++;
            if (vr !== (r == 3)) begin
                nerr++;
                $display("FAIL basic_vr%0d: got vr=%b, want %b", r, vr, (r == 3));
            end
        end
        @(negedge clk);
        nvec++;
        if ({ov, busy, vr} !== 3'b001) begin
            nerr++;
            $display("FAIL basic_back_to_idle: got ov=%b busy=%b vr=%b, want 0 0 1", ov, busy, vr);
        end
    endtask

    task automatic test_stall();
        vv = 1'b1; vec = mkvec(8'h00); ctrl = 4'h3; ordy = 1'b1;
        @(negedge clk);
        vv = 1'b0;
        #1;
        nvec++;
        if ({od, orank} !== {8'h0F, 2'd0}) begin
            nerr++;
            $display("FAIL stall_beat0: got od=%h rank=%0d, want 0f 0", od, orank);
        end
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            ordy = 1'b0;
            #1;
            nvec++;
            if ({ov, od, orank, vr} !== {1'b1, 8'h0E, 2'd1, 1'b0}) begin
                nerr++;
                $display("FAIL stall_hold%0d: got ov=%b od=%h rank=%0d vr=%b, want 1 0e 1 0", s, ov, od, orank, vr);
            end
            @(negedge clk);
        end
        ordy = 1'b1;
        #1;
        nvec++;
        if ({ov, od, orank, vr} !== {1'b1, 8'h0E, 2'd1, 1'b0}) begin
            nerr++;
            $display("FAIL stall_release: got ov=%b od=%h rank=%0d vr=%b, want 1 0e 1 0", ov, od, orank, vr);
        end
        @(negedge clk);
        #1;
        nvec++;
        if ({od, orank} !== {8'h0D, 2'd2}) begin
            nerr++;
            $display("FAIL stall_beat2: got od=%h rank=%0d, want 0d 2", od, orank);
        end
        @(negedge clk);
        #1;
        nvec++;
        if ({od, orank, olast, vr} !== {8'h0C, 2'd3, 1'b1, 1'b1}) begin
            nerr++;
            $display("FAIL stall_beat3: got od=%h rank=%0d last=%b vr=%b, want 0c 3 1 1", od, orank, olast, vr);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        vv = 1'b1; vec = mkvec(8'h00); ctrl = 4'h1; ordy = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            vv = 1'b0;
            #1;
            exp_d = 8'h0F - 8'(r);
            nvec++;
            if (od !== exp_d) begin
                nerr++;
                $display("FAIL b2b_first%0d: got od=%h, want %h", r, od, exp_d);
            end
        end
        @(negedge clk);
        vv = 1'b1; vec = mkvec(8'h10); ctrl = 4'h5;
        #1;
        nvec++;
        if ({od, olast, octrl, vr} !== {8'h0C, 1'b1, 4'h1, 1'b1}) begin
            nerr++;
            $display("FAIL b2b_last_beat: got od=%h last=%b ctrl=%h vr=%b, want 0c 1 1 1", od, olast, octrl, vr);
        end
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            vv = 1'b0;
            #1;
            exp_d = 8'h1F - 8'(r);
            nvec++;
            if ({ov, od, orank, olast, octrl} !== {1'b1, exp_d, 2'(r), (r == 3), 4'h5}) begin
                nerr++;
                $display("FAIL b2b_second%0d: got ov=%b od=%h rank=%0d last=%b ctrl=%h, want 1 %h %0d %b 5",
                         r, ov, od, orank, olast, octrl, exp_d, r, (r == 3));
            end
        end
        @(negedge clk);
        nvec++;
        if ({ov, busy} !== 2'b00) begin
            nerr++;
            $display("FAIL b2b_idle: got ov=%b busy=%b, want 0 0", ov, busy);
        end
    endtask

    task automatic test_signed();
        logic [7:0] exp_s [4] = '{8'h7F, 8'h01, 8'hFF, 8'h80};
        logic [127:0] v;
        for (int j = 0; j < 16; j++) v[j*8 +: 8] = 8'h80;
        v[15*8 +: 8] = 8'h7F;
        v[14*8 +: 8] = 8'h01;
        v[13*8 +: 8] = 8'hFF;
        v[12*8 +: 8] = 8'h80;
        vv = 1'b1; vec = v; ctrl = 4'h1; ordy = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            vv = 1'b0;
            #1;
            nvec++;
            if ({ov, od, orank, octrl[0]} !== {1'b1, exp_s[r], 2'(r), 1'b1}) begin
                nerr++;
                $display("FAIL signed_beat%0d: got ov=%b od=%h rank=%0d sign=%b, want 1 %h %0d 1",
                         r, ov, od, orank, octrl[0], exp_s[r], r);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drain();
        vv = 1'b1; vec = mkvec(8'h00); ctrl = 4'h6; ordy = 1'b1;
        @(negedge clk);
        vv = 1'b0;
        @(negedge clk);
        #1;
        nvec++;
        if ({od, orank} !== {8'h0E, 2'd1}) begin
            nerr++;
            $display("FAIL rstmid_rank1: got od=%h rank=%0d, want 0e 1", od, orank);
        end
        rst = 1'b1;
        #1;
        nvec++;
        if ({ov, od, orank, olast, octrl, busy, vr} !== {1'b0, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1}) begin
            nerr++;
            $display("FAIL rstmid_outputs: got ov=%b od=%h rank=%0d last=%b ctrl=%h busy=%b vr=%b, want 0,00,0,0,0,0,1",
                     ov, od, orank, olast, octrl, busy, vr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if ({ov, busy} !== 2'b00) begin
            nerr++;
            $display("FAIL rstmid_dropped: got ov=%b busy=%b, want 0 0", ov, busy);
        end
        vv = 1'b1; vec = mkvec(8'h20); ctrl = 4'h7;
        @(negedge clk);
        vv = 1'b0;
        #1;
        nvec++;
        if ({ov, od, orank, octrl} !== {1'b1, 8'h2F, 2'd0, 4'h7}) begin
            nerr++;
            $display("FAIL rstmid_next_first: got ov=%b od=%h rank=%0d ctrl=%h, want 1 2f 0 7", ov, od, orank, octrl);
        end
        repeat (4) @(negedge clk);
    endtask

    // Random-handshake scoreboard run on the K=1 (sel=0) or K=16 (sel=1) instance.
    task automatic test_k_build(input int sel);
        beat_t      q[$];
        beat_t      b;
        int         kk = (sel != 0) ? 16 : 1;
        int         sent = 0;
        int         cyc = 0;
        logic       pend = 1'b0;
        logic       rdy, exp_vr, o_v, o_l, o_vr;
        logic [7:0] o_d;
        logic [3:0] o_c;
        int         o_r;
        logic [127:0] v;
        while ((sent < 6 || q.size() != 0) && cyc < 600) begin
            @(negedge clk);
            cyc++;
            rdy = 1'($urandom_range(0, 1));
            if (!pend && sent < 6) pend = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < 16; j++) v[j*8 +: 8] = 8'(sent*5 + j*15);
            s_or[sel] = rdy;
            s_vv[sel] = pend;
            s_vec[sel] = v;
            s_ctrl[sel] = 4'(sent);
            #1;
            o_v = s_ov[sel]; o_d = s_od[sel]; o_l = s_last[sel]; o_c = s_octrl[sel]; o_vr = s_vr[sel];
            o_r = (sel != 0) ? int'(rankn) : int'(rank1);
            exp_vr = (q.size() == 0) || (q.size() == 1 && rdy);
            nvec++;
            if ({o_v, o_vr} !== {(q.size() != 0), exp_vr}) begin
                nerr++;
                $display("FAIL k%0d_handshake cyc%0d: got ov=%b vr=%b, want %b %b",
                         kk, cyc, o_v, o_vr, (q.size() != 0), exp_vr);
            end
            if (q.size() != 0 && rdy) begin
                b = q.pop_front();
                nvec++;
                if (o_d !== b.d || o_r != b.r || o_l !== b.l || o_c !== b.c) begin
                    nerr++;
                    $display("FAIL k%0d_beat cyc%0d: got d=%h r=%0d l=%b c=%h, want d=%h r=%0d l=%b c=%h",
                             kk, cyc, o_d, o_r, o_l, o_c, b.d, b.r, b.l, b.c);
                end
            end
            if (pend && exp_vr) begin
                for (int r = 0; r < kk; r++) begin
                    b.d = 8'(sent*5 + (15-r)*15);
                    b.r = r;
                    b.l = (r == kk-1);
                    b.c = 4'(sent);
                    q.push_back(b);
                end
                sent++;
                pend = 1'b0;
            end
        end
        s_vv[sel] = 1'b0;
        s_or[sel] = 1'b0;
        nvec++;
        if (sent != 6 || q.size() != 0) begin
            nerr++;
            $display("FAIL k%0d_timeout: got sent=%0d pending=%0d, want 6 0", kk, sent, q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            s_vv[i] = 1'b0; s_vec[i] = '0; s_ctrl[i] = '0; s_or[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_signed();
        test_reset_mid_drain();
        test_k_build(0);
        test_k_build(1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
